data_mem_controller: RTL and testbench
======================================

// Module: data_mem_controller
// PURPOSE
//   Memory-side responder for the MEM stage of the RV32IM pipeline. Consumes MEM_READ/MEM_WRITE/FUNCT3 issued
//   by the control unit. Performs byte/half/word loads and stores on an internal word array with a
//   configurable multi-cycle latency. Drives BUSY_WAIT back to the control unit and pipeline so every stage
//   stalls until the access completes.
// PARAMETERS
//   DEPTH    256  number of 32-bit words in the array (byte address range 0 .. 4*DEPTH-1)
//   LATENCY  4    cycles BUSY_WAIT stays high per access; legal range >= 2
// PORTS
//   CLK          in   1   clock; all state updates on the rising edge
//   RESET_N      in   1   asynchronous active-low reset
//   MEM_READ     in   1   load request from the MEM-stage control signals
//   MEM_WRITE    in   1   store request from the MEM-stage control signals
//   FUNCT3       in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores: 000/001/010 only)
//   ADDRESS      in   32  byte address (ALU result)
//   WRITE_DATA   in   32  store data (rs2), right-aligned
//   READ_DATA    out  32  registered load result, extended to 32 bits
//   BUSY_WAIT    out  1   high = stall the pipeline
//   ACCESS_FAULT out  1   one-cycle pulse with completion of an illegal access
// BEHAVIOUR
//   Reset (async, RESET_N=0): state IDLE, counter 0, READ_DATA=0, BUSY_WAIT=0, ACCESS_FAULT=0.
//     Array contents are not cleared. Reset mid-access aborts it; a pending store is not performed.
//   FSM states: IDLE, ACCESS, DONE.
//   IDLE:
//     - BUSY_WAIT = MEM_READ|MEM_WRITE (combinational, so the request cycle already stalls).
//     - On a request, capture ADDRESS, WRITE_DATA, FUNCT3 and the request type; load counter with
//       LATENCY-2; go to ACCESS.
//   ACCESS:
//     - BUSY_WAIT=1; counter decrements each cycle.
//     - At counter==0 the array operation executes on the edge: the store commits, or READ_DATA is loaded.
//       Then go to DONE.
//     - Total BUSY_WAIT-high cycles per access = LATENCY exactly.
//   DONE:
//     - BUSY_WAIT=0 for exactly one cycle; READ_DATA is valid and the pipeline advances on this edge.
//     - Requests present in DONE are ignored (they belong to the instruction leaving MEM).
//     - Next state is always IDLE. Back-to-back accesses are therefore separated by one DONE cycle.
//   READ_DATA holds its value until the next completed load. Stores and faults leave it unchanged,
//     except that faulting loads return 0.
//   Lanes are little-endian: byte lane = ADDRESS[1:0]; half lane = ADDRESS[1]; word index = ADDRESS[31:2].
//   Load extension:
//     - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
//   Store merge:
//     - SB writes 1 byte lane, SH writes 2 lanes, SW writes all 4.
//     - Other lanes are preserved (read-modify-write on the captured word).
//   Fault conditions, checked on the captured request:
//     - H/HU with ADDRESS[0]=1
//     - W with ADDRESS[1:0]!=0
//     - word index >= DEPTH
//     - illegal FUNCT3 (loads 011/110/111; stores anything other than 000/001/010)
//     - MEM_READ and MEM_WRITE both high
//   Fault handling:
//     - The full LATENCY stall still occurs; there is no array write.
//     - A faulting load sets READ_DATA=0.
//     - ACCESS_FAULT=1 during the DONE cycle only.
//   Inputs are sampled only in IDLE; changes during ACCESS have no effect.
// STRUCTURE
//   Shared header mem_defines.vh:
//     - FUNCT3 load/store encodings (LB..LHU, SB..SW)
//     - FSM state encodings IDLE/ACCESS/DONE
//   Sub-module mem_align_unit (combinational) holds the lane select, sign/zero extension, store byte-merge
//     and misalignment detect. The controller keeps the FSM, counter, capture registers and array.
// TESTING
//   1. SW 0xDEADBEEF @0x10, then LW @0x10 (LATENCY=4):
//      - each access has BUSY_WAIT high 4 cycles, then 1 low DONE cycle.
//      - READ_DATA = 0xDEADBEEF in DONE.
//   2. After test 1, LB @0x10 -> 0xFFFFFFEF; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD;
//      LHU @0x10 -> 0x0000BEEF.
//   3. SB 0x12 @0x11, then LW @0x10:
//      - result 0xDEAD12EF; the other bytes are preserved.
//   4. Faults:
//      - LW @0x12 -> ACCESS_FAULT pulse in DONE, READ_DATA=0, 4-cycle stall.
//      - SH @0x21 -> fault, and a later LW @0x20 shows the word unchanged.
//      - MEM_READ=MEM_WRITE=1 -> fault.
//      - address 4*DEPTH -> fault.
//   5. Assert RESET_N=0 in the 2nd ACCESS cycle of SW 0x55 @0x30 (0x30 previously 0):
//      - BUSY_WAIT and READ_DATA go to 0 immediately.
//      - a later LW @0x30 returns 0x00000000.
//   6. Hold MEM_READ high continuously for LW @0x10:
//      - IDLE, 4 busy cycles, DONE (request ignored), then a new 4-cycle access starts.
//      - no extra busy cycle in DONE.

Source files
------------

// File: rtl/data_mem_controller_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_controller_pkg
//   Shared definitions for the MEM-stage data memory controller:
//   - FUNCT3 load/store encodings (LB..LHU, SB..SW)
//   - FSM state encoding (IDLE / ACCESS / DONE)
//   - the captured-request record held for the duration of an access
// -----------------------------------------------------------------------------
package data_mem_controller_pkg;

    // Load encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Request as sampled in IDLE; the pipeline inputs are ignored afterwards.
    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/data_mem_controller_align.sv
// -----------------------------------------------------------------------------
// data_mem_controller_align  (memory align unit, purely combinational)
//   Lane selection, load sign/zero extension, store byte-merge and
//   misalignment / illegal-FUNCT3 detection for one 32-bit word.
// Ports
//   funct3_i      access size/sign
//   lane_i        ADDRESS[1:0] of the access (little-endian byte lane)
//   is_store_i    1 = store, 0 = load (selects the legal FUNCT3 set)
//   word_i        current contents of the addressed word
//   wdata_i       right-aligned store data
//   load_data_o   extended load result
//   store_word_o  word_i with the store lanes replaced
//   misaligned_o  half on odd byte, or word not on a word boundary
//   bad_funct3_o  FUNCT3 not legal for this access type
// -----------------------------------------------------------------------------
module data_mem_controller_align
    import data_mem_controller_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  lane_i,
    input  logic        is_store_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o,
    output logic        misaligned_o,
    output logic        bad_funct3_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned, which would infer a latch.
    always_comb begin
        byte_sel    = word_i[{lane_i, 3'b000} +: 8];
        half_sel    = word_i[{lane_i[1], 4'b0000} +: 16];

        load_data_o = '0;
        unique case (funct3_i)
            F3_LB:   load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  load_data_o = {24'h0, byte_sel};
            F3_LH:   load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  load_data_o = {16'h0, half_sel};
            F3_LW:   load_data_o = word_i;
            default: load_data_o = '0;
        endcase

        // Read-modify-write: untouched lanes keep the stored bytes.
        store_word_o = word_i;
        case (funct3_i)
            F3_SB:   store_word_o[{lane_i, 3'b000} +: 8]     = wdata_i[7:0];
            F3_SH:   store_word_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            F3_SW:   store_word_o = wdata_i;
            default: store_word_o = word_i;
        endcase

        case (funct3_i)
            F3_LH, F3_LHU: misaligned_o = lane_i[0];
            F3_LW:         misaligned_o = |lane_i;
            default:       misaligned_o = 1'b0;
        endcase

        if (is_store_i) begin
            bad_funct3_o = !(funct3_i inside {F3_SB, F3_SH, F3_SW});
        end else begin
            bad_funct3_o = !(funct3_i inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
        end
    end

endmodule

// File: rtl/data_mem_controller.sv
// -----------------------------------------------------------------------------
// data_mem_controller
//   MEM-stage data memory responder. Captures a load/store request in IDLE,
//   stalls the pipeline for exactly LATENCY cycles, performs the access on the
//   last busy edge, then spends one DONE cycle with BUSY_WAIT low so the
//   pipeline advances.
// Ports
//   CLK, RESET_N   clock (rising edge), asynchronous active-low reset
//   MEM_READ       load request
//   MEM_WRITE      store request
//   FUNCT3         access size/sign
//   ADDRESS        byte address
//   WRITE_DATA     right-aligned store data
//   READ_DATA      registered load result
//   BUSY_WAIT      stall request to the pipeline
//   ACCESS_FAULT   one-cycle pulse in DONE when the access was illegal
// -----------------------------------------------------------------------------
module data_mem_controller
    import data_mem_controller_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSY_WAIT,
    output logic        ACCESS_FAULT
);

    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW       = $clog2(LATENCY);
    // The request cycle and the final ACCESS cycle account for two of the
    // LATENCY busy cycles, so the counter covers the rest.
    localparam logic [CW-1:0]   CNT_LOAD = CW'(LATENCY - 2);
    localparam logic [29:0]     DEPTH_W  = 30'(DEPTH);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    req_t           req_q,   req_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           fault_q, fault_d;

    logic [31:0]    mem_q [DEPTH];

    logic [AW-1:0]  word_idx;
    logic [31:0]    mem_word;
    logic [31:0]    load_data;
    logic [31:0]    store_word;
    logic           misaligned;
    logic           bad_funct3;
    logic           out_of_range;
    logic           fault;
    logic           commit;
    logic           mem_we;

    assign word_idx     = req_q.addr[AW+1:2];
    assign mem_word     = mem_q[word_idx];
    assign out_of_range = (req_q.addr[31:2] >= DEPTH_W);
    assign fault        = (req_q.rd && req_q.wr) || bad_funct3 || misaligned || out_of_range;
    assign commit       = (state_q == ST_ACCESS) && (cnt_q == '0);
    assign mem_we       = commit && req_q.wr && !fault;

    data_mem_controller_align u_align (
        .funct3_i     (req_q.funct3),
        .lane_i       (req_q.addr[1:0]),
        .is_store_i   (req_q.wr),
        .word_i       (mem_word),
        .wdata_i      (req_q.wdata),
        .load_data_o  (load_data),
        .store_word_o (store_word),
        .misaligned_o (misaligned),
        .bad_funct3_o (bad_funct3)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        rdata_d   = rdata_q;
        fault_d   = 1'b0;
        BUSY_WAIT = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Combinational so the request cycle itself already stalls.
                BUSY_WAIT = MEM_READ | MEM_WRITE;
                if (MEM_READ || MEM_WRITE) begin
                    req_d   = '{rd: MEM_READ, wr: MEM_WRITE, funct3: FUNCT3,
                                addr: ADDRESS, wdata: WRITE_DATA};
                    cnt_d   = CNT_LOAD;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                BUSY_WAIT = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    fault_d = fault;
                    if (req_q.rd) begin
                        rdata_d = fault ? 32'h0 : load_data;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            // Requests seen here belong to the instruction leaving MEM.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // NOTE: the array has no reset; clearing it would turn a RAM into flops.
    // An aborted store never commits because reset forces the FSM to IDLE.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[word_idx] <= store_word;
        end
    end

    assign READ_DATA    = rdata_q;
    assign ACCESS_FAULT = fault_q;

endmodule

// File: tb/tb_data_mem_controller.sv
module tb_data_mem_controller;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 4;

    logic        CLK;
    logic        RESET_N;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [2:0]  FUNCT3;
    logic [31:0] ADDRESS;
    logic [31:0] WRITE_DATA;
    logic [31:0] READ_DATA;
    logic        BUSY_WAIT;
    logic        ACCESS_FAULT;

    int n_checks = 0;
    int n_fail   = 0;

    data_mem_controller #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .MEM_READ     (MEM_READ),
        .MEM_WRITE    (MEM_WRITE),
        .FUNCT3       (FUNCT3),
        .ADDRESS      (ADDRESS),
        .WRITE_DATA   (WRITE_DATA),
        .READ_DATA    (READ_DATA),
        .BUSY_WAIT    (BUSY_WAIT),
        .ACCESS_FAULT (ACCESS_FAULT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        chk_rdata;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Caller is positioned just after a rising edge with the DUT in IDLE.
    // Returns the number of busy cycles and the values seen in the DONE cycle.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             output int nbusy, output logic [31:0] rdata,
                             output logic flt, output logic done_seen);
        MEM_READ   = rd;
        MEM_WRITE  = wr;
        FUNCT3     = f3;
        ADDRESS    = a;
        WRITE_DATA = wd;
        nbusy      = 0;
        rdata      = '0;
        flt        = 1'b0;
        done_seen  = 1'b0;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            @(negedge CLK);
            if (BUSY_WAIT) begin
                nbusy++;
            end else if (nbusy > 0) begin
                done_seen = 1'b1;
                rdata     = READ_DATA;
                flt       = ACCESS_FAULT;
            end
            @(posedge CLK);
            #1;
            MEM_READ  = 1'b0;
            MEM_WRITE = 1'b0;
        end
    endtask

    initial begin
        int          nbusy;
        logic [31:0] rdata;
        logic        flt;
        logic        done_seen;

        // {name, rd, wr, f3, addr, wdata, exp READ_DATA, check READ_DATA, exp fault}
        vecs.push_back('{"sw_10",        1'b0, 1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{"lw_10",        1'b1, 1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b1, 1'b0});
        vecs.push_back('{"lb_10",        1'b1, 1'b0, 3'b000, 32'h10,  32'h0,        32'hFFFFFFEF, 1'b1, 1'b0});
        vecs.push_back('{"lbu_13",       1'b1, 1'b0, 3'b100, 32'h13,  32'h0,        32'h000000DE, 1'b1, 1'b0});
        vecs.push_back('{"lh_12",        1'b1, 1'b0, 3'b001, 32'h12,  32'h0,        32'hFFFFDEAD, 1'b1, 1'b0});
        vecs.push_back('{"lhu_10",       1'b1, 1'b0, 3'b101, 32'h10,  32'h0,        32'h0000BEEF, 1'b1, 1'b0});
        vecs.push_back('{"sb_11",        1'b0, 1'b1, 3'b000, 32'h11,  32'h00000012, 32'h0000BEEF, 1'b1, 1'b0});
        vecs.push_back('{"lw_10_merged", 1'b1, 1'b0, 3'b010, 32'h10,  32'h0,        32'hDEAD12EF, 1'b1, 1'b0});
        vecs.push_back('{"lb_11",        1'b1, 1'b0, 3'b000, 32'h11,  32'h0,        32'h00000012, 1'b1, 1'b0});
        vecs.push_back('{"lw_12_misal",  1'b1, 1'b0, 3'b010, 32'h12,  32'h0,        32'h00000000, 1'b1, 1'b1});
        vecs.push_back('{"sw_20",        1'b0, 1'b1, 3'b010, 32'h20,  32'hCAFEF00D, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{"sh_21_misal",  1'b0, 1'b1, 3'b001, 32'h21,  32'h00001234, 32'h00000000, 1'b1, 1'b1});
        vecs.push_back('{"lw_20_intact", 1'b1, 1'b0, 3'b010, 32'h20,  32'h0,        32'hCAFEF00D, 1'b1, 1'b0});
        vecs.push_back('{"rd_and_wr",    1'b1, 1'b1, 3'b010, 32'h20,  32'h0,        32'h00000000, 1'b0, 1'b1});
        vecs.push_back('{"lhu_22",       1'b1, 1'b0, 3'b101, 32'h22,  32'h0,        32'h0000CAFE, 1'b1, 1'b0});
        vecs.push_back('{"lw_oor",       1'b1, 1'b0, 3'b010, 32'h400, 32'h0,        32'h00000000, 1'b1, 1'b1});
        vecs.push_back('{"lhu_22_again", 1'b1, 1'b0, 3'b101, 32'h22,  32'h0,        32'h0000CAFE, 1'b1, 1'b0});
        vecs.push_back('{"st_f3_100",    1'b0, 1'b1, 3'b100, 32'h20,  32'h0,        32'h0000CAFE, 1'b1, 1'b1});
        vecs.push_back('{"ld_f3_011",    1'b1, 1'b0, 3'b011, 32'h20,  32'h0,        32'h00000000, 1'b1, 1'b1});
        vecs.push_back('{"sh_22",        1'b0, 1'b1, 3'b001, 32'h22,  32'h0000BEEF, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{"lw_20_sh",     1'b1, 1'b0, 3'b010, 32'h20,  32'h0,        32'hBEEFF00D, 1'b1, 1'b0});
        vecs.push_back('{"sw_30_zero",   1'b0, 1'b1, 3'b010, 32'h30,  32'h0,        32'hBEEFF00D, 1'b1, 1'b0});
        vecs.push_back('{"sb_3ff",       1'b0, 1'b1, 3'b000, 32'h3FF, 32'h00000080, 32'hBEEFF00D, 1'b1, 1'b0});
        vecs.push_back('{"lb_3ff",       1'b1, 1'b0, 3'b000, 32'h3FF, 32'h0,        32'hFFFFFF80, 1'b1, 1'b0});

        RESET_N    = 1'b0;
        MEM_READ   = 1'b0;
        MEM_WRITE  = 1'b0;
        FUNCT3     = 3'b000;
        ADDRESS    = '0;
        WRITE_DATA = '0;
        #12;
        check("reset_busy",  {31'b0, BUSY_WAIT},    32'h0);
        check("reset_rdata", READ_DATA,             32'h0);
        check("reset_fault", {31'b0, ACCESS_FAULT}, 32'h0);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;

        foreach (vecs[i]) begin
            do_access(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                      nbusy, rdata, flt, done_seen);
            check({vecs[i].name, "_done"},  {31'b0, done_seen}, 32'h1);
            check({vecs[i].name, "_busy"},  nbusy,              LATENCY);
            check({vecs[i].name, "_fault"}, {31'b0, flt},       {31'b0, vecs[i].exp_fault});
            if (vecs[i].chk_rdata) begin
                check({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
            end
        end

        // Fault pulse lasts one cycle only: back in IDLE it is low again.
        @(negedge CLK);
        check("fault_cleared_idle", {31'b0, ACCESS_FAULT}, 32'h0);
        @(posedge CLK);
        #1;

        // Reset in the 2nd ACCESS cycle of SW 0x55 @0x30 aborts the store.
        MEM_WRITE  = 1'b1;
        FUNCT3     = 3'b010;
        ADDRESS    = 32'h30;
        WRITE_DATA = 32'h55;
        @(posedge CLK);
        #1;
        MEM_WRITE = 1'b0;
        @(posedge CLK);
        #2;
        RESET_N = 1'b0;
        #1;
        check("abort_busy",  {31'b0, BUSY_WAIT}, 32'h0);
        check("abort_rdata", READ_DATA,          32'h0);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        do_access(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, nbusy, rdata, flt, done_seen);
        check("lw_30_after_abort_done",  {31'b0, done_seen}, 32'h1);
        check("lw_30_after_abort_busy",  nbusy,              LATENCY);
        check("lw_30_after_abort_rdata", rdata,              32'h0);

        // MEM_READ held high across two accesses: DONE must not stall.
        MEM_READ = 1'b1;
        FUNCT3   = 3'b010;
        ADDRESS  = 32'h10;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            check($sformatf("held_busy_c%0d", c), {31'b0, BUSY_WAIT},
                  {31'b0, (c % 5) != 4});
            if (c == 4) begin
                check("held_rdata_done", READ_DATA, 32'hDEAD12EF);
            end
        end
        @(posedge CLK);
        #1;
        MEM_READ = 1'b0;
        @(negedge CLK);
        check("held_released_idle", {31'b0, BUSY_WAIT}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
